alu_seq: RTL and testbench

- Parametrised multi-cycle ALU, successor to the single-cycle datapath ALU.
- Takes operand Y (from the Y register) and operand B (from the bus) plus a 5-bit opcode on a start pulse.
- Produces a registered 2×WIDTH result split into zlo/zhi for the Z register.
- Adds iterative signed Booth multiply, iterative signed divide, variable shift/rotate amounts, arithmetic shift right, a start/done handshake and a divide-by-zero flag.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_muldiv_iter.sv | 90 +++++++++
 rtl/alu_seq.sv | 106 ++++++++++
 tb/tb_alu_seq.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and FSM state encoding for alu_seq
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_SHRA = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - start/done operand and result bundle for alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] b_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] zlo;
  logic [WIDTH-1:0] zhi;
  logic             div_zero;

  modport master (
    output start, op, y_in, b_in,
    input  ready, done, zlo, zhi, div_zero
  );

  modport slave (
    input  start, op, y_in, b_in,
    output ready, done, zlo, zhi, div_zero
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative Booth multiply / restoring divide datapath
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             load,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH:0]   acc, acc_nx, booth_sum, shifted, diff;
  logic [WIDTH-1:0] q, q_nx, m, y_mag, b_mag;
  logic             q1, mode_r, neg_q, neg_r;
  logic [CNT_W-1:0] cnt;

  assign y_mag = y[WIDTH-1] ? -y : y;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  // acc carries one guard bit so Booth can subtract the most-negative multiplicand
  always_comb begin
    booth_sum = acc;
    shifted   = {acc[WIDTH-1:0], q[WIDTH-1]};
    diff      = shifted - {1'b0, m};
    acc_nx    = acc;
    q_nx      = q;
    if (!mode_r) begin
      case ({q[0], q1})
        2'b01:   booth_sum = acc + {m[WIDTH-1], m};
        2'b10:   booth_sum = acc - {m[WIDTH-1], m};
        default: booth_sum = acc;
      endcase
      acc_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      q_nx   = {booth_sum[0], q[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_nx = diff;
      q_nx   = {q[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = shifted;
      q_nx   = {q[WIDTH-2:0], 1'b0};
    end
  end

  assign res_lo = (mode_r && neg_q) ? -q_nx : q_nx;
  assign res_hi = (mode_r && neg_r) ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      q1     <= 1'b0;
      mode_r <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      q1     <= 1'b0;
      cnt    <= '0;
      mode_r <= mode;
      if (mode) begin
        m     <= b_mag;
        q     <= y_mag;
        neg_q <= y[WIDTH-1] ^ b[WIDTH-1];
        neg_r <= y[WIDTH-1];
      end else begin
        m     <= y;
        q     <= b;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end
    end else if (step) begin
      acc <= acc_nx;
      q   <= q_nx;
      q1  <= q[0];
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle ops, Booth multiply, signed divide
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clock,
  input  logic      clear_n,
  alu_seq_if.slave  bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  state_t             state;
  logic               load, step, last, is_div;
  logic [WIDTH-1:0]   res_lo, res_hi, alu_res;
  logic [SHAMT_W-1:0] shamt;

  assign shamt  = bus.b_in[SHAMT_W-1:0];
  assign is_div = (bus.op == OP_DIV);
  assign load   = (state == S_IDLE) && bus.start;
  assign step   = (state == S_MUL) || (state == S_DIV);

  // shifting by WIDTH yields zero, so a rotate by 0 degenerates cleanly to y
  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = bus.y_in + bus.b_in;
      OP_SUB:  alu_res = bus.y_in - bus.b_in;
      OP_SHR:  alu_res = bus.y_in >> shamt;
      OP_SHL:  alu_res = bus.y_in << shamt;
      OP_ROR:  alu_res = (bus.y_in >> shamt) | (bus.y_in << (WIDTH - int'(shamt)));
      OP_ROL:  alu_res = (bus.y_in << shamt) | (bus.y_in >> (WIDTH - int'(shamt)));
      OP_AND:  alu_res = bus.y_in & bus.b_in;
      OP_OR:   alu_res = bus.y_in | bus.b_in;
      OP_SHRA: alu_res = $signed(bus.y_in) >>> shamt;
      OP_NEG:  alu_res = -bus.b_in;
      OP_NOT:  alu_res = ~bus.b_in;
      default: alu_res = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clock   (clock),
    .clear_n (clear_n),
    .load    (load),
    .mode    (is_div),
    .step    (step),
    .y       (bus.y_in),
    .b       (bus.b_in),
    .last    (last),
    .res_lo  (res_lo),
    .res_hi  (res_hi)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state        <= S_IDLE;
      bus.ready    <= 1'b1;
      bus.done     <= 1'b0;
      bus.zlo      <= '0;
      bus.zhi      <= '0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.ready    <= 1'b0;
            bus.div_zero <= 1'b0;
            if (bus.op == OP_MUL) begin
              state <= S_MUL;
            end else if (is_div && (bus.b_in != '0)) begin
              state <= S_DIV;
            end else if (is_div) begin
              state        <= S_DONE;
              bus.done     <= 1'b1;
              bus.div_zero <= 1'b1;
              bus.zlo      <= '1;
              bus.zhi      <= bus.y_in;
            end else begin
              state    <= S_DONE;
              bus.done <= 1'b1;
              bus.zlo  <= alu_res;
              bus.zhi  <= {WIDTH{alu_res[WIDTH-1]}};
            end
          end
        end
        S_MUL, S_DIV: begin
          if (last) begin
            state    <= S_DONE;
            bus.done <= 1'b1;
            bus.zlo  <= res_lo;
            bus.zhi  <= res_hi;
          end
        end
        default: begin
          state     <= S_IDLE;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    int          due;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  int   e = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t expq[$];
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;
  logic        last_dz = 1'b0;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) e <= e + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: signed products/quotients via 64-bit arithmetic, shifts bit-by-bit
  function automatic void model(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic dz, output int lat);
    logic [31:0] r;
    longint p, qq, rr;
    int s;
    s = int'(b[4:0]);
    dz = 1'b0;
    lat = 1;
    r = '0;
    case (op)
      OP_ADD:  r = y + b;
      OP_SUB:  r = y - b;
      OP_SHR:  r = y >> s;
      OP_SHL:  r = y << s;
      OP_ROR:  begin r = y; for (int i = 0; i < s; i++) r = {r[0], r[31:1]}; end
      OP_ROL:  begin r = y; for (int i = 0; i < s; i++) r = {r[30:0], r[31]}; end
      OP_AND:  r = y & b;
      OP_OR:   r = y | b;
      OP_SHRA: begin r = y; for (int i = 0; i < s; i++) r = {r[31], r[31:1]}; end
      OP_NEG:  r = 32'd0 - b;
      OP_NOT:  r = ~b;
      default: r = '0;
    endcase
    lo = r;
    hi = {32{r[31]}};
    if (op == OP_MUL) begin
      p = longint'($signed(y)) * longint'($signed(b));
      lo = p[31:0];
      hi = p[63:32];
      lat = 33;
    end else if (op == OP_DIV && b == 0) begin
      dz = 1'b1;
      lo = '1;
      hi = y;
    end else if (op == OP_DIV) begin
      qq = longint'($signed(y)) / longint'($signed(b));
      rr = longint'($signed(y)) % longint'($signed(b));
      lo = qq[31:0];
      hi = rr[31:0];
      lat = 33;
    end
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b, input int hold);
    int n;
    exp_t x;
    int lat;
    n = 0;
    @(negedge clock);
    while (!bus.ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.ready) chk("ready_timeout", {63'd0, bus.ready}, 64'd1);
    bus.start = 1'b1;
    bus.op = op;
    bus.y_in = y;
    bus.b_in = b;
    @(posedge clock);
    #1;
    model(op, y, b, x.lo, x.hi, x.dz, lat);
    x.due = e + lat - 1;
    expq.push_back(x);
    last_dz = 1'b0;
    for (int i = 1; i < hold; i++) begin
      @(posedge clock);
      #1;
    end
    bus.start = 1'b0;
    bus.op = 5'($urandom);
    bus.y_in = $urandom;
    bus.b_in = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (expq.size() > 0) begin
      chk("drain_timeout", 64'(expq.size()), 64'd0);
      expq.delete();
    end
  endtask

  // Compare process: every cycle out of reset, done must match the schedule and outputs must hold
  always @(negedge clock) begin
    if (clear_n) begin
      if (expq.size() > 0 && e > expq[0].due) begin
        chk("done_missing", 64'(e), 64'(expq[0].due));
        expq.delete(0);
      end
      if (expq.size() > 0 && e == expq[0].due) begin
        chk("done_pulse", {63'd0, bus.done}, 64'd1);
        chk("zlo", {32'd0, bus.zlo}, {32'd0, expq[0].lo});
        chk("zhi", {32'd0, bus.zhi}, {32'd0, expq[0].hi});
        chk("div_zero", {63'd0, bus.div_zero}, {63'd0, expq[0].dz});
        chk("ready_in_done", {63'd0, bus.ready}, 64'd0);
        last_lo = expq[0].lo;
        last_hi = expq[0].hi;
        last_dz = expq[0].dz;
        expq.delete(0);
      end else begin
        chk("done_quiet", {63'd0, bus.done}, 64'd0);
        chk("zlo_hold", {32'd0, bus.zlo}, {32'd0, last_lo});
        chk("zhi_hold", {32'd0, bus.zhi}, {32'd0, last_hi});
        chk("div_zero_hold", {63'd0, bus.div_zero}, {63'd0, last_dz});
        chk("ready_level", {63'd0, bus.ready}, {63'd0, expq.size() == 0});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lo, hi;
    logic dz;
    int lat;

    bus.start = 1'b0;
    bus.op = '0;
    bus.y_in = '0;
    bus.b_in = '0;
    #12;
    chk("rst_ready", {63'd0, bus.ready}, 64'd1);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_zlo", {32'd0, bus.zlo}, 64'd0);
    chk("rst_zhi", {32'd0, bus.zhi}, 64'd0);
    chk("rst_div_zero", {63'd0, bus.div_zero}, 64'd0);
    #6 clear_n = 1'b1;

    // Hand-computed pins on the reference model
    model(OP_MUL, 32'hFFFFFFFD, 32'd7, lo, hi, dz, lat);
    chk("pin_mul_lo", {32'd0, lo}, 64'hFFFFFFEB);
    chk("pin_mul_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("pin_mul_lat", 64'(lat), 64'd33);
    model(OP_MUL, 32'h80000000, 32'h80000000, lo, hi, dz, lat);
    chk("pin_mulmin", {hi, lo}, 64'h40000000_00000000);
    model(OP_DIV, 32'hFFFFFFEF, 32'd5, lo, hi, dz, lat);
    chk("pin_div", {hi, lo}, 64'hFFFFFFFE_FFFFFFFD);
    model(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lo, hi, dz, lat);
    chk("pin_divmin", {hi, lo}, 64'h00000000_80000000);
    model(OP_DIV, 32'h12345678, 32'd0, lo, hi, dz, lat);
    chk("pin_div0", {hi, lo}, 64'h12345678_FFFFFFFF);
    chk("pin_div0_flag", {63'd0, dz}, 64'd1);
    chk("pin_div0_lat", 64'(lat), 64'd1);
    model(OP_ROR, 32'h80000001, 32'd4, lo, hi, dz, lat);
    chk("pin_ror", {32'd0, lo}, 64'h18000000);
    model(OP_ROL, 32'h80000001, 32'd1, lo, hi, dz, lat);
    chk("pin_rol", {32'd0, lo}, 64'h00000003);
    model(OP_SHRA, 32'h80000000, 32'd31, lo, hi, dz, lat);
    chk("pin_shra", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
    model(OP_SHR, 32'h80000000, 32'd31, lo, hi, dz, lat);
    chk("pin_shr", {32'd0, lo}, 64'h00000001);
    model(OP_ADD, 32'h7FFFFFFF, 32'd1, lo, hi, dz, lat);
    chk("pin_add", {hi, lo}, 64'hFFFFFFFF_80000000);
    model(5'b11111, 32'h1234, 32'h5678, lo, hi, dz, lat);
    chk("pin_undef", {hi, lo}, 64'd0);

    issue(OP_ADD, 32'h7FFFFFFF, 32'd1, 1);
    issue(OP_MUL, 32'hFFFFFFFD, 32'd7, 1);
    issue(OP_MUL, 32'h80000000, 32'h80000000, 1);
    issue(OP_MUL, 32'h12345678, 32'h9ABCDEF0, 1);
    issue(OP_DIV, 32'hFFFFFFEF, 32'd5, 1);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1);
    issue(OP_DIV, 32'd100, 32'hFFFFFFF9, 1);
    issue(OP_DIV, 32'h12345678, 32'd0, 1);
    issue(OP_ADD, 32'd2, 32'd3, 1);
    issue(OP_ROR, 32'h80000001, 32'd4, 1);
    issue(OP_ROL, 32'h80000001, 32'd1, 1);
    issue(OP_SHRA, 32'h80000000, 32'd31, 1);
    issue(OP_SHR, 32'h80000000, 32'd31, 1);
    issue(OP_SHL, 32'h0000F00F, 32'hFFFFFFE4, 1);
    issue(OP_ROR, 32'hDEADBEEF, 32'd32, 1);
    issue(OP_SUB, 32'd5, 32'd9, 1);
    issue(OP_AND, 32'hF0F0FF00, 32'h3C3C0FF0, 1);
    issue(OP_OR, 32'hF0F00000, 32'h0000F0F0, 1);
    issue(OP_NEG, 32'd0, 32'd1, 1);
    issue(5'b11111, 32'hFFFF, 32'hFFFF, 1);
    issue(OP_ADD, 32'd10, 32'd20, 2);

    issue(OP_MUL, 32'd123456, 32'hFFFFFC18, 1);
    repeat (4) @(posedge clock);
    #1;
    bus.start = 1'b1;
    bus.op = OP_ADD;
    bus.y_in = 32'd1;
    bus.b_in = 32'd1;
    chk("ready_busy", {63'd0, bus.ready}, 64'd0);
    @(posedge clock);
    #1 bus.start = 1'b0;
    drain();

    issue(OP_DIV, 32'h7FFFFFFF, 32'd3, 1);
    repeat (9) @(posedge clock);
    #2 clear_n = 1'b0;
    expq.delete();
    last_lo = '0;
    last_hi = '0;
    last_dz = 1'b0;
    #1;
    chk("abort_ready", {63'd0, bus.ready}, 64'd1);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_zlo", {32'd0, bus.zlo}, 64'd0);
    chk("abort_zhi", {32'd0, bus.zhi}, 64'd0);
    @(posedge clock);
    #3 clear_n = 1'b1;
    repeat (40) @(negedge clock);

    issue(OP_NOT, 32'h5555AAAA, 32'd0, 1);
    drain();
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
